// File: rtl/xmss_wots_pkg.sv
// rtl/xmss_wots_pkg.sv - shared WOTS+ constants and sequencer state type
package xmss_wots_pkg;

  localparam int WOTS_W     = 16;
  localparam int WOTS_LOG_W = 4;
  localparam int LEN1       = 64;
  localparam int LEN2       = 3;
  localparam int LEN        = LEN1 + LEN2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_CSUM = 2'd2,
    ST_FIN  = 2'd3
  } wots_state_e;

endpackage

// File: rtl/wots_base_w_csum.sv
// rtl/wots_base_w_csum.sv - base-w digit stream of a digest followed by its WOTS+ checksum digits
// Optional XMSS_WOTS_CSUM_OUT_EN adds the csum_out port holding the final checksum.
module wots_base_w_csum #(
  parameter int KEY_LEN = 256,
  parameter int WOTS_W  = 16,
  parameter int LEN1    = 64,
  parameter int LEN2    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] msg_in,
  input  logic               digit_ready,
  output logic               digit_valid,
  output logic [3:0]         digit_out,
  output logic [6:0]         digit_idx,
  output logic               digit_last,
  output logic               busy,
  output logic               done
`ifdef XMSS_WOTS_CSUM_OUT_EN
  ,
  output logic [9:0]         csum_out
`endif
);
  import xmss_wots_pkg::*;

  localparam int DW = $clog2(WOTS_W);
  localparam logic [6:0] MSG_LAST   = 7'(LEN1 - 1);
  localparam logic [6:0] CSUM_FIRST = 7'(LEN1);
  localparam logic [6:0] CSUM_MID   = 7'(LEN1 + 1);
  localparam logic [6:0] CSUM_LAST  = 7'(LEN1 + LEN2 - 1);

  wots_state_e        state_q;
  wots_state_e        state_d;
  logic [KEY_LEN-1:0] msg_q;
  logic [9:0]         csum_q;
  logic [11:0]        csum12;
  logic [6:0]         idx_q;
  logic               xfer;
  logic               accept;

  assign csum12 = {2'b00, csum_q};
  assign xfer   = digit_valid && digit_ready;
  assign accept = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    digit_valid = 1'b0;
    digit_out   = 4'd0;
    digit_idx   = 7'd0;
    digit_last  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_MSG;
      end
      ST_MSG: begin
        digit_valid = 1'b1;
        busy        = 1'b1;
        digit_idx   = idx_q;
        digit_out   = msg_q[KEY_LEN-1 -: DW];
        if (digit_ready && idx_q == MSG_LAST) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        digit_valid = 1'b1;
        busy        = 1'b1;
        digit_idx   = idx_q;
        digit_last  = (idx_q == CSUM_LAST);
        if (idx_q == CSUM_FIRST)    digit_out = csum12[11:8];
        else if (idx_q == CSUM_MID) digit_out = csum12[7:4];
        else                        digit_out = csum12[3:0];
        if (digit_ready && digit_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The digest is shifted left so the current digit is always the top nibble;
  // 15 - d equals ~d for a 4-bit digit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      msg_q  <= '0;
      csum_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      msg_q  <= msg_in;
      csum_q <= '0;
      idx_q  <= '0;
    end else if (xfer) begin
      idx_q <= idx_q + 7'd1;
      if (state_q == ST_MSG) begin
        msg_q  <= msg_q << DW;
        csum_q <= csum_q + {6'd0, ~msg_q[KEY_LEN-1 -: DW]};
      end
    end
  end

`ifdef XMSS_WOTS_CSUM_OUT_EN
  logic [9:0] csum_out_q;

  always_ff @(posedge clk) begin
    if (!reset)                                       csum_out_q <= '0;
    else if (accept)                                  csum_out_q <= '0;
    else if (state_q == ST_CSUM && xfer && digit_last) csum_out_q <= csum_q;
  end

  assign csum_out = csum_out_q;
`endif

endmodule

// File: doc/wots_base_w_csum.md
WOTS_BASE_W_CSUM -- requirements
Module: wots_base_w_csum

Interface
REQ-001 Parameter KEY_LEN, default 256, message digest width in bits.
REQ-002 Parameter WOTS_W, default 16, Winternitz parameter; only 16 supported (log2 = 4).
REQ-003 Parameter LEN1, default 64, message digits (KEY_LEN/4); LEN2, default 3, checksum digits.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  single-cycle request; sampled only in IDLE.
REQ-007 msg_in  in  KEY_LEN  digest; sampled on the accepted start cycle only.
REQ-008 digit_ready  in  1  consumer (gen_chain sequencer) accepts digit_out.
REQ-009 digit_valid  out  1  digit_out/digit_idx/digit_last hold a valid digit.
REQ-010 digit_out  out  4  base-w digit, used downstream as chain start_step/end_step.
REQ-011 digit_idx  out  7  chain index 0..66.
REQ-012 digit_last  out  1  high with digit_idx = 66.
REQ-013 busy  out  1  high from the cycle after accepted start until done.
REQ-014 done  out  1  one-cycle pulse after the final transfer.

Function
REQ-015 FSM states IDLE, MSG, CSUM, FIN; IDLE->MSG on start; MSG->CSUM after transfer of idx 63; CSUM->FIN after transfer of idx 66; FIN->IDLE next cycle with done=1.
REQ-016 Transfer occurs on a rising edge with digit_valid && digit_ready; at most one transfer per cycle.
REQ-017 Digit order MSB-first: idx k (0..63) = msg_in[KEY_LEN-1-4k -: 4].
REQ-018 Checksum csum = sum over idx 0..63 of (15 - digit), 10-bit unsigned, max 960, never wraps.
REQ-019 Checksum digits: idx 64 = csum[11:8], idx 65 = csum[7:4], idx 66 = csum[3:0], csum zero-extended to 12 bits (equivalent to the csum<<4, 2-byte base_w rule).
REQ-020 csum accumulates on each message-digit transfer; idx 64 is not valid before idx 63 has transferred.
REQ-021 Latency: digit_valid rises the cycle after accepted start; with digit_ready held high, idx k transfers in cycle k+1 and done pulses in cycle 68.
REQ-022 While digit_valid && !digit_ready, digit_out, digit_idx and digit_last are held stable.
REQ-023 start while busy is ignored; msg_in changes after acceptance have no effect.
REQ-024 start and done may coincide only in IDLE-adjacent FIN; start in FIN is ignored.

Reset
REQ-025 reset=0 at a clock edge forces IDLE; digit_valid, digit_out, digit_idx, digit_last, busy, done, csum all 0.
REQ-026 Reset mid-stream aborts; no done pulse; the next start restarts at idx 0 with csum 0.

Configuration
REQ-027 Macro XMSS_WOTS_CSUM_OUT_EN defined: extra output csum_out (10 bits) presents the final csum, valid from the FIN cycle until the next accepted start, reset to 0.
REQ-028 Macro undefined: port csum_out and its register absent; all other behaviour identical.

Structure
REQ-029 Package xmss_wots_pkg holds WOTS_W, WOTS_LOG_W, LEN1, LEN2, LEN (=67) and the FSM state typedef, shared with the chain sequencer.
REQ-030 Single module; no sub-module (digit extraction is a shift of a latched message register).

Verification
REQ-031 msg_in all 0, ready high -> idx 0..63 digit 0, csum 960, idx 64..66 = 3,C,0, done at cycle 68.
REQ-032 msg_in all F -> 64 digits F, csum 0, idx 64..66 = 0,0,0, digit_last with idx 66.
REQ-033 msg_in 0x66d0132b... -> idx 0..3 = 6,6,D,0; full stream and csum match software base_w/wots_checksum model.
REQ-034 digit_ready low 5 cycles at idx 10 -> outputs frozen, no duplicated/skipped index, done delayed 5 cycles.
REQ-035 reset low at idx 30 -> all outputs 0 next cycle, no done; new start (all 0) -> REQ-031 result.
REQ-036 start pulsed at idx 20 with different msg_in -> ignored, stream unchanged.
